// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - 4-way round-robin arbiter driving a shared W-bit 4:1 data path
// Optional hold limit on contended grants: define RR_ARB_HOLD_LIMIT_EN.
module rr_mux_arbiter #(
  parameter int W        = 8,
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         valid,
  output logic [W-1:0] y
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic       force_rel;
  logic       release_now;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef RR_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt;
  logic       at_limit;
  assign at_limit  = (hold_cnt == 8'(HOLD_MAX - 1));
  assign force_rel = at_limit && (|others);
`else
  assign force_rel = 1'b0;
`endif

  assign others      = req & ~gnt;
  assign pick_idle   = rr_pick(req, ptr);
  assign pick_next   = rr_pick(others, sel + 2'd1);
  assign release_now = !req[sel] || force_rel;

  always_comb begin
    y = '0;
    if (valid) begin
      case (sel)
        2'd0:    y = in0;
        2'd1:    y = in1;
        2'd2:    y = in2;
        default: y = in3;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
      valid <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            state <= GRANT;
            sel   <= pick_idle[1:0];
            gnt   <= 4'b0001 << pick_idle[1:0];
            valid <= 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= sel + 2'd1;
            if (pick_next[2]) begin
              sel <= pick_next[1:0];
              gnt <= 4'b0001 << pick_next[1:0];
`ifdef RR_ARB_HOLD_LIMIT_EN
              hold_cnt <= 8'd0;
`endif
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              valid <= 1'b0;
            end
          end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
            // Uncontended owner at the limit simply starts a fresh hold window.
            hold_cnt <= at_limit ? 8'd0 : hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - randomized and directed bench for rr_mux_arbiter against a behavioural model
module tb_rr_mux_arbiter;
  localparam int W  = 8;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] in0, in1, in2, in3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         valid;
  logic [W-1:0] y;

  int checks = 0;
  int errors = 0;

  // Model state: owner index or -1 when idle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_hold  = 0;

  rr_mux_arbiter #(.W(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .gnt(gnt), .sel(sel), .valid(valid), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start, input int skip);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (start + i) % 4;
      if (r[k] && k != skip) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rn);
    int nxt;
    bit forced;
    if (!rn) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      nxt = first_from(r, m_ptr, -1);
      if (nxt >= 0) begin m_owner = nxt; m_sel = nxt; m_hold = 0; end
    end else begin
      forced = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      if (m_hold == HM - 1 && first_from(r, 0, m_owner) >= 0) forced = 1'b1;
`endif
      if (!r[m_owner] || forced) begin
        m_ptr = (m_owner + 1) % 4;
        nxt = first_from(r, m_ptr, m_owner);
        if (nxt >= 0) begin m_owner = nxt; m_sel = nxt; m_hold = 0; end
        else m_owner = -1;
      end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
        m_hold = (m_hold == HM - 1) ? 0 : m_hold + 1;
`endif
      end
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic rn);
    logic [W-1:0] exp_y;
    logic [3:0]   exp_g;
    @(negedge clk);
    req = r; rst_n = rn;
    in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
    @(posedge clk);
    model_step(r, rn);
    #1;
    exp_g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    case (m_owner)
      0: exp_y = in0;
      1: exp_y = in1;
      2: exp_y = in2;
      3: exp_y = in3;
      default: exp_y = '0;
    endcase
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("valid", 32'(valid), 32'(m_owner >= 0));
    chk("y", 32'(y), 32'(exp_y));
  endtask

  initial begin
    logic [3:0] r;
    req = 4'b0000; rst_n = 1'b0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;

    // Reset with all requests pending, then first grant goes to requester 0.
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    cycle(4'b1111, 1'b1);
    chk("first_gnt", 32'(gnt), 32'h1);

    // Rotation with direct handover.
    cycle(4'b1110, 1'b1); chk("rot1", 32'(gnt), 32'h2);
    cycle(4'b1101, 1'b1); chk("rot2", 32'(gnt), 32'h4);
    cycle(4'b1011, 1'b1); chk("rot3", 32'(gnt), 32'h8);
    cycle(4'b0011, 1'b1); chk("wrap0", 32'(gnt), 32'h1);
    cycle(4'b0010, 1'b1); chk("wrap1", 32'(gnt), 32'h2);
    cycle(4'b0000, 1'b1); chk("idle", 32'(valid), 32'd0);

    // Single request then drop.
    @(negedge clk);
    cycle(4'b0100, 1'b1);
    chk("single_sel", 32'(sel), 32'd2);
    cycle(4'b0000, 1'b1);
    chk("single_drop_y", 32'(y), 32'd0);

    // Mid-grant reset: owner 2, then reset, then scan restarts at 0.
    cycle(4'b0100, 1'b1);
    cycle(4'b0110, 1'b0);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    cycle(4'b0110, 1'b1);
    chk("midrst_after", 32'(gnt), 32'h2);

    // Constant contention exercises the hold limit when enabled.
    for (int i = 0; i < 20; i++) cycle(4'b0011, 1'b1);
    cycle(4'b0000, 1'b1);

    // Random traffic with sticky requests and occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      else if ($urandom_range(0, 2) == 0) r = r & ~gnt;
      cycle(r, ($urandom_range(0, 49) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
